fetch_stage: RTL and testbench

Fetch stage and IF/ID pipeline register for the pipelined RV32I core. Holds the program counter, drives the instruction-memory address, and registers the fetched instruction into Decode. It consumes the hazard unit's `stallF`, `stallD` and `flushD` controls and the Execute-stage branch redirect. It also counts stall and flush cycles for performance bring-up.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls and redirect in, fetch address and IF/ID contents out.
// The master side is the hazard unit and the instruction memory; the slave side is fetch_stage.
interface fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             pcsrcE;
  logic [31:0]      pcTargetE;
  logic [31:0]      instrF;
  logic             instrValidF;
  logic [31:0]      pcF;
  logic [31:0]      instrD;
  logic [31:0]      pcD;
  logic [31:0]      pcPlus4D;
  logic             validD;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output stallF, stallD, flushD, pcsrcE, pcTargetE, instrF, instrValidF,
    input  pcF, instrD, pcD, pcPlus4D, validD, stallCount, flushCount
  );

  modport slave (
    input  stallF, stallD, flushD, pcsrcE, pcTargetE, instrF, instrValidF,
    output pcF, instrD, pcD, pcPlus4D, validD, stallCount, flushCount
  );
endinterface

// File: rtl/fetch_stage.sv
// PC register plus IF/ID register; pcF->instrD is 1 cycle, redirect lands on pcF the cycle after.
// Backpressure: stallF/stallD hold PC and IF/ID, a fetch miss holds PC and bubbles Decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_pc;
  logic [31:0]      r_instr_d;
  logic [31:0]      r_pc_d;
  logic [31:0]      r_pc_plus4_d;
  logic             r_valid_d;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [31:0]      w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Redirect wins over both stall and a fetch miss so a taken branch is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (bus.pcsrcE) begin
      r_pc <= bus.pcTargetE;
    end else if (!bus.stallF && bus.instrValidF) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else if (bus.flushD) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else if (!bus.stallD) begin
      if (bus.instrValidF) begin
        r_instr_d    <= bus.instrF;
        r_pc_d       <= r_pc;
        r_pc_plus4_d <= w_pc_plus4;
        r_valid_d    <= 1'b1;
      end else begin
        r_instr_d    <= NOP_INSTR;
        r_pc_d       <= 32'd0;
        r_pc_plus4_d <= 32'd0;
        r_valid_d    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.stallD && !bus.flushD) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (bus.flushD)                r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign bus.pcF        = r_pc;
  assign bus.instrD     = r_instr_d;
  assign bus.pcD        = r_pc_d;
  assign bus.pcPlus4D   = r_pc_plus4_d;
  assign bus.validD     = r_valid_d;
  assign bus.stallCount = r_stall_cnt;
  assign bus.flushCount = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory model returns pcF<<2 combinationally.
module tb_fetch_stage;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fetch_stage_if #(.CNT_W(32)) bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013),
    .CNT_W    (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.instrF = bus.pcF << 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stallF = 0; bus.stallD = 0; bus.flushD = 0; bus.pcsrcE = 0;
    bus.pcTargetE = 32'd0; bus.instrValidF = 1'b1;
    step(); step();
    n_cmp++; if (bus.pcF !== 32'h0) begin n_err++; $display("FAIL reset_pcF got %h want %h", bus.pcF, 32'h0); end
    n_cmp++; if (bus.instrD !== 32'h13) begin n_err++; $display("FAIL reset_instrD got %h want %h", bus.instrD, 32'h13); end
    n_cmp++; if (bus.pcD !== 32'h0 || bus.pcPlus4D !== 32'h0) begin n_err++; $display("FAIL reset_pcD got %h/%h want 0/0", bus.pcD, bus.pcPlus4D); end
    n_cmp++; if (bus.validD !== 1'b0) begin n_err++; $display("FAIL reset_validD got %b want 0", bus.validD); end
    n_cmp++; if (bus.stallCount !== 32'd0 || bus.flushCount !== 32'd0) begin n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.stallCount, bus.flushCount); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.pcF !== 32'h0) begin n_err++; $display("FAIL release_pcF got %h want %h", bus.pcF, 32'h0); end
  endtask

  task automatic test_fetch();
    step();
    n_cmp++; if (bus.pcF !== 32'h4) begin n_err++; $display("FAIL fetch1_pcF got %h want %h", bus.pcF, 32'h4); end
    n_cmp++; if (bus.instrD !== 32'h0 || bus.pcD !== 32'h0 || bus.pcPlus4D !== 32'h4 || bus.validD !== 1'b1) begin
      n_err++; $display("FAIL fetch1_ifid got %h/%h/%h/%b want 0/0/4/1", bus.instrD, bus.pcD, bus.pcPlus4D, bus.validD); end
    step();
    n_cmp++; if (bus.pcF !== 32'h8) begin n_err++; $display("FAIL fetch2_pcF got %h want %h", bus.pcF, 32'h8); end
    n_cmp++; if (bus.instrD !== 32'h10 || bus.pcD !== 32'h4 || bus.pcPlus4D !== 32'h8) begin
      n_err++; $display("FAIL fetch2_ifid got %h/%h/%h want 10/4/8", bus.instrD, bus.pcD, bus.pcPlus4D); end
  endtask

  task automatic test_stall();
    bus.stallF = 1'b1; bus.stallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (bus.pcF !== 32'h8 || bus.instrD !== 32'h10 || bus.pcD !== 32'h4) begin
        n_err++; $display("FAIL stall_hold%0d got %h/%h/%h want 8/10/4", i, bus.pcF, bus.instrD, bus.pcD); end
    end
    n_cmp++; if (bus.stallCount !== 32'd2) begin n_err++; $display("FAIL stall_count got %0d want 2", bus.stallCount); end
    bus.stallF = 1'b0; bus.stallD = 1'b0;
    step();
    n_cmp++; if (bus.pcF !== 32'hC || bus.instrD !== 32'h20 || bus.pcD !== 32'h8) begin
      n_err++; $display("FAIL stall_resume got %h/%h/%h want c/20/8", bus.pcF, bus.instrD, bus.pcD); end
  endtask

  task automatic test_branch();
    bus.pcsrcE = 1'b1; bus.pcTargetE = 32'h100; bus.flushD = 1'b1;
    bus.stallF = 1'b1; bus.stallD = 1'b1;
    step();
    bus.pcsrcE = 1'b0; bus.flushD = 1'b0; bus.stallF = 1'b0; bus.stallD = 1'b0;
    n_cmp++; if (bus.pcF !== 32'h100) begin n_err++; $display("FAIL branch_pcF got %h want %h", bus.pcF, 32'h100); end
    n_cmp++; if (bus.instrD !== 32'h13 || bus.validD !== 1'b0) begin
      n_err++; $display("FAIL branch_squash got %h/%b want 13/0", bus.instrD, bus.validD); end
    n_cmp++; if (bus.flushCount !== 32'd1 || bus.stallCount !== 32'd2) begin
      n_err++; $display("FAIL branch_counts got %0d/%0d want 1/2", bus.flushCount, bus.stallCount); end
    step();
    n_cmp++; if (bus.pcD !== 32'h100 || bus.instrD !== 32'h400 || bus.pcPlus4D !== 32'h104 || bus.validD !== 1'b1) begin
      n_err++; $display("FAIL branch_target_d got %h/%h/%h/%b want 100/400/104/1", bus.pcD, bus.instrD, bus.pcPlus4D, bus.validD); end
  endtask

  task automatic test_miss();
    bus.pcsrcE = 1'b1; bus.pcTargetE = 32'h20;
    step();
    bus.pcsrcE = 1'b0;
    n_cmp++; if (bus.pcF !== 32'h20) begin n_err++; $display("FAIL miss_setup_pcF got %h want %h", bus.pcF, 32'h20); end
    bus.instrValidF = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.pcF !== 32'h20 || bus.validD !== 1'b0 || bus.instrD !== 32'h13) begin
        n_err++; $display("FAIL miss_bubble%0d got %h/%b/%h want 20/0/13", i, bus.pcF, bus.validD, bus.instrD); end
    end
    bus.instrValidF = 1'b1;
    step();
    n_cmp++; if (bus.pcD !== 32'h20 || bus.pcPlus4D !== 32'h24 || bus.instrD !== 32'h80 || bus.validD !== 1'b1) begin
      n_err++; $display("FAIL miss_recover got %h/%h/%h/%b want 20/24/80/1", bus.pcD, bus.pcPlus4D, bus.instrD, bus.validD); end
    n_cmp++; if (bus.pcF !== 32'h24) begin n_err++; $display("FAIL miss_pcF_next got %h want %h", bus.pcF, 32'h24); end
  endtask

  task automatic test_wrap();
    bus.pcsrcE = 1'b1; bus.pcTargetE = 32'hFFFF_FFFC;
    step();
    bus.pcsrcE = 1'b0;
    n_cmp++; if (bus.pcF !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_target got %h want %h", bus.pcF, 32'hFFFF_FFFC); end
    step();
    n_cmp++; if (bus.pcF !== 32'h0) begin n_err++; $display("FAIL wrap_pcF got %h want %h", bus.pcF, 32'h0); end
    n_cmp++; if (bus.pcD !== 32'hFFFF_FFFC || bus.pcPlus4D !== 32'h0 || bus.instrD !== 32'hFFFF_FFF0) begin
      n_err++; $display("FAIL wrap_ifid got %h/%h/%h want fffffffc/0/fffffff0", bus.pcD, bus.pcPlus4D, bus.instrD); end
  endtask

  task automatic test_async_reset();
    bus.stallF = 1'b1; bus.stallD = 1'b1;
    step();
    n_cmp++; if (bus.stallCount !== 32'd3 || bus.flushCount !== 32'd1) begin
      n_err++; $display("FAIL pre_rst_counts got %0d/%0d want 3/1", bus.stallCount, bus.flushCount); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.pcF !== 32'h0 || bus.instrD !== 32'h13 || bus.pcD !== 32'h0 || bus.pcPlus4D !== 32'h0 || bus.validD !== 1'b0) begin
      n_err++; $display("FAIL async_rst_regs got %h/%h/%h/%h/%b want 0/13/0/0/0", bus.pcF, bus.instrD, bus.pcD, bus.pcPlus4D, bus.validD); end
    n_cmp++; if (bus.stallCount !== 32'd0 || bus.flushCount !== 32'd0) begin
      n_err++; $display("FAIL async_rst_counts got %0d/%0d want 0/0", bus.stallCount, bus.flushCount); end
    bus.stallF = 1'b0; bus.stallD = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_miss();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
